seq_detector_fsm: RTL and testbench

Parametrised serial pattern detector and successor to the single-bit toggle FSM. It compares a validated serial bit stream against a runtime-loaded pattern of 1..PAT_W bits, with overlapping or non-overlapping match mode. The match output is Moore-registered and a saturating count of matches is kept. It sits between a serial front end (UART/SPI deserialiser or GPIO sampler) and control logic that needs frame-sync or keyword hits.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/sat_counter.sv | 23 ++
 rtl/seq_detector_fsm.sv | 138 +++++++++++++
 tb/tb_seq_detector_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, legal PAT_W range, cfg_len width helper.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    HUNT  = 2'd2,
    MATCH = 2'd3
  } state_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;

  // cfg_len must be able to hold the value PAT_W itself, hence the +1.
  function automatic int calc_len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: q reflects clr/inc on the edge that samples them.
// Backpressure: none; increments past all-ones are dropped (no wrap).
// Ports: clk, rst (sync, active-high), clr, inc, q[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_fsm.sv
// Serial pattern detector: matches a qualified bit stream against a runtime pattern of 1..PAT_W bits.
// Latency: match is Moore-registered, visible the cycle after the edge sampling the completing bit.
// Backpressure: none; din is consumed whenever din_valid is high in HUNT/MATCH, ignored otherwise.
// Ports: clk, rst (sync, active-high); cfg_load/cfg_pattern/cfg_len/cfg_overlap config strobe;
//        din_valid/din serial input; cnt_clear; armed, match, match_count, cfg_err outputs.
module seq_detector_fsm
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = calc_len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             din_valid,
  input  logic             din,
  input  logic             cnt_clear,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_detector_fsm: PAT_W outside supported range");
  end

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [LEN_W-1:0] fill;
  logic             cfg_err_q;

  logic             cfg_legal;
  logic             accept;
  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W:0]   fill_inc;
  logic             fill_ok;
  logic             pat_eq;
  logic             hit;

  assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign accept     = din_valid && ((state == HUNT) || (state == MATCH));

  // Newest bit enters at [0], so the last len bits received line up with pattern[len-1:0].
  assign hist_shift = {hist[PAT_W-2:0], din};

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // One extra bit so fill+1 cannot wrap when fill == PAT_W.
  assign fill_inc = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
  assign fill_ok  = (fill_inc >= {1'b0, len_q});
  assign pat_eq   = (((hist_shift ^ pat_q) & len_mask) == '0);
  assign hit      = accept && fill_ok && pat_eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      ARM:     state_nxt = HUNT;
      HUNT:    state_nxt = hit ? MATCH : HUNT;
      MATCH:   state_nxt = hit ? MATCH : HUNT;
      default: state_nxt = IDLE;
    endcase
    // A config strobe overrides whatever the data path would have done this cycle.
    if (cfg_load) begin
      state_nxt = cfg_legal ? ARM : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_load && !cfg_legal;
      if (cfg_load) begin
        // The bit arriving with cfg_load is dropped; ARM clears history next cycle.
        if (cfg_legal) begin
          pat_q <= cfg_pattern;
          len_q <= cfg_len;
          ovl_q <= cfg_overlap;
        end
      end else if (state == ARM) begin
        hist <= '0;
        fill <= '0;
      end else if (accept) begin
        hist <= hist_shift;
        // Non-overlap restarts the fill count; stale hist bits are masked by fill_ok.
        if (hit && !ovl_q) begin
          fill <= '0;
        end else if (fill < len_q) begin
          fill <= fill_inc[LEN_W-1:0];
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clear),
    .inc (hit && !cfg_load),
    .q   (match_count)
  );

  assign match   = (state == MATCH);
  assign armed   = (state == HUNT) || (state == MATCH);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Scoreboard bench for seq_detector_fsm (PAT_W=8, CNT_W=2 so saturation is reachable).
// Latency: each driven cycle's expected outputs are checked 1 time unit after the next rising edge.
// Backpressure: n/a.
module tb_seq_detector_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       din_valid;
  logic       din;
  logic       cnt_clear;
  logic       armed;
  logic       match;
  logic [1:0] match_count;
  logic       cfg_err;

  typedef struct packed {
    logic       m;
    logic       a;
    logic [1:0] c;
    logic       e;
  } obs_t;

  typedef struct {
    int   phase;
    int   stepn;
    obs_t exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   phase    = 0;
  int   stepn    = 0;

  always #5 clk = ~clk;

  seq_detector_fsm #(
    .PAT_W (8),
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din_valid   (din_valid),
    .din         (din),
    .cnt_clear   (cnt_clear),
    .armed       (armed),
    .match       (match),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic ld, input logic vld, input logic d,
                     input logic clr, input logic em, input logic ea, input int ec,
                     input logic ee);
    exp_t x;
    @(posedge clk);
    #2;
    rst       = r;
    cfg_load  = ld;
    din_valid = vld;
    din       = d;
    cnt_clear = clr;
    x.phase   = phase;
    x.stepn   = stepn;
    x.exp.m   = em;
    x.exp.a   = ea;
    x.exp.c   = ec[1:0];
    x.exp.e   = ee;
    sb.push_back(x);
    stepn++;
  endtask

  task automatic setcfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
  endtask

  // Monitor: compares DUT outputs after each edge against the oldest queued expectation.
  initial begin
    exp_t x;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        got.m = match;
        got.a = armed;
        got.c = match_count;
        got.e = cfg_err;
        checks++;
        if (got !== x.exp) begin
          failures++;
          $display("FAIL phase%0d step%0d: got match=%b armed=%b count=%0d cfg_err=%b, expected match=%b armed=%b count=%0d cfg_err=%b",
                   x.phase, x.stepn, got.m, got.a, got.c, got.e,
                   x.exp.m, x.exp.a, x.exp.c, x.exp.e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_load = 1'b0; din_valid = 1'b0; din = 1'b0; cnt_clear = 1'b0;
    setcfg(8'h00, 4'd0, 1'b0);

    // Reset with din toggling; then load config -> ARM, then armed.
    phase = 0;
    cyc(1, 0, 1, 0, 0,  0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0,  0, 0, 0, 0);
    phase = 1;
    setcfg(8'b1011, 4'd4, 1'b1);
    cyc(0, 1, 0, 0, 0,  0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 0, 0);
    // Overlapping: 1,0,1,1,0,1,1 -> hits on bits 4 and 7.
    cyc(0, 0, 1, 1, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0,  0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 2, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 2, 0);

    // Non-overlapping: same stream -> single hit on bit 4.
    phase = 2;
    setcfg(8'b1011, 4'd4, 1'b0);
    cyc(0, 1, 0, 0, 1,  0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0,  0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 1, 0);

    // Toggle-equivalent len 1: 1,1,0,1 then invalid gaps.
    phase = 3;
    setcfg(8'b1, 4'd1, 1'b1);
    cyc(0, 1, 0, 0, 1,  0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 2, 0);
    cyc(0, 0, 1, 0, 0,  0, 1, 2, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 3, 0);
    cyc(0, 0, 0, 1, 0,  0, 1, 3, 0);
    cyc(0, 0, 0, 1, 0,  0, 1, 3, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 3, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 3, 0);

    // Saturation at 3, then clear colliding with a hit.
    phase = 4;
    cyc(0, 0, 0, 0, 1,  0, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 1, 1, 0,  1, 1, (i > 3) ? 3 : i, 0);
    end
    cyc(0, 0, 1, 1, 1,  1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 0, 0);

    // Reload mid-pattern discards the completing bit; reload drops match, keeps count.
    phase = 5;
    setcfg(8'b1011, 4'd4, 1'b1);
    cyc(0, 1, 0, 0, 0,  0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 0, 0);
    cyc(0, 1, 1, 1, 0,  0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0,  0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 1, 0);

    // Illegal lengths 0 and 9: one-cycle cfg_err, IDLE, din ignored.
    phase = 6;
    setcfg(8'b1011, 4'd0, 1'b1);
    cyc(0, 1, 0, 0, 0,  0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0,  0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0,  0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0,  0, 0, 1, 0);
    setcfg(8'b1011, 4'd9, 1'b1);
    cyc(0, 1, 0, 0, 0,  0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0,  0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0,  0, 0, 1, 0);

    // Reset mid-operation wins over cfg_load and a hit; config is cleared.
    phase = 7;
    setcfg(8'b1, 4'd1, 1'b1);
    cyc(0, 1, 0, 0, 0,  0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0,  0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0,  1, 1, 2, 0);
    cyc(1, 1, 1, 1, 0,  0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0,  0, 0, 0, 0);

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
